// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter in front of a single-port word memory.
//
// Ports
//   clk, rst              single clock, synchronous active-low reset
//   m0_*/m1_*             master request side: req, we, addr, wdata in;
//                         gnt, ack, err, rdata out (m0 additionally has lock)
//   mem_wf/addr/wdata     memory write flag, byte address, write data
//   mem_rdata             combinational big-endian word at mem_addr
//   dbg_state             current FSM state (IDLE=0, ACCESS=1, RESP=2)
//
// Handshake: a master raises req with stable we/addr/wdata(/lock) and holds
// it until it sees ack.  gnt is high for the single ACCESS cycle, and
// ack/err are high for exactly the following cycle, when rdata is valid.
// A req dropped before it is granted simply leaves no trace.
module mem_arbiter #(
    parameter int MEM_BYTES = 65536,
    parameter int HOLD_MAX  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    input  logic        m0_lock,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic        m0_err,
    output logic        m1_err,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        mem_wf,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int              HW        = $clog2(HOLD_MAX + 2);
    localparam logic [HW-1:0]   HOLD_LIM  = HW'(HOLD_MAX);
    localparam logic [31:0]     ADDR_LAST = 32'(MEM_BYTES - 4);

    state_t        state;
    logic          last_m1;   // last grant went to m1
    logic [HW-1:0] hold;      // consecutive locked m0 grants

    logic          any_req;
    logic          pick_m1;
    logic          sel_we;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic          illegal;
    logic          m0_locked_again;

    assign any_req         = m0_req | m1_req;
    assign m0_locked_again = m0_lock && !last_m1;

    // Winner of the arbitration taken at this edge (only used in IDLE/RESP).
    always_comb begin
        pick_m1 = 1'b0;
        if (m1_req && !m0_req) begin
            pick_m1 = 1'b1;
        end else if (m1_req && m0_req) begin
            if (m0_locked_again)
                pick_m1 = (hold == HOLD_LIM);
            else
                pick_m1 = !last_m1;
        end
    end

    // Attributes of the master owning the current ACCESS cycle.
    always_comb begin
        sel_we    = m0_we;
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        if (m1_gnt) begin
            sel_we    = m1_we;
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
        end
    end

    assign illegal   = (sel_addr[1:0] != 2'b00) || (sel_addr > ADDR_LAST);
    assign mem_addr  = (state == ACCESS) ? sel_addr  : 32'h0;
    assign mem_wdata = (state == ACCESS) ? sel_wdata : 32'h0;
    // rst gates the write combinationally so a reset aborts an in-flight write.
    assign mem_wf    = (state == ACCESS) && sel_we && !illegal && rst;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            last_m1  <= 1'b1;
            hold     <= '0;
            m0_gnt   <= 1'b0;
            m1_gnt   <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m1_err   <= 1'b0;
            m0_rdata <= 32'h0;
            m1_rdata <= 32'h0;
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_err <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (any_req) begin
                        state   <= ACCESS;
                        m0_gnt  <= !pick_m1;
                        m1_gnt  <= pick_m1;
                        last_m1 <= pick_m1;
                        // Only a locked m0 grant following an m0 grant extends the hold run.
                        if (!pick_m1 && m0_locked_again)
                            hold <= (hold == HOLD_LIM) ? hold : hold + 1'b1;
                        else
                            hold <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    state  <= RESP;
                    m0_gnt <= 1'b0;
                    m1_gnt <= 1'b0;
                    if (m1_gnt) begin
                        m1_ack   <= 1'b1;
                        m1_err   <= illegal;
                        m1_rdata <= (!illegal && !sel_we) ? mem_rdata : 32'h0;
                    end else begin
                        m0_ack   <= 1'b1;
                        m0_err   <= illegal;
                        m0_rdata <= (!illegal && !sel_we) ? mem_rdata : 32'h0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
